// File: rtl/wbs_pwm_pkg.sv
// ============================================================================
// wbs_pwm_pkg : register map, control bit positions and counter width
// Revision    : 1.0
// ============================================================================
`default_nettype none

package wbs_pwm_pkg;

    localparam int CNT_W  = 8;
    localparam int DAT_W  = 8;
    localparam int MAX_CH = 4;

    localparam logic [2:0] ADR_PRESCALE = 3'd4;
    localparam logic [2:0] ADR_CONTROL  = 3'd5;
    localparam logic [2:0] ADR_COUNTER  = 3'd6;

    localparam int CTRL_RUN = 7;

endpackage

`default_nettype wire

// File: rtl/pwm_channel_shadow.sv
// ============================================================================
// pwm_channel_shadow : one channel -- shadow/active duty, compare, output flop
// Revision           : 1.0
// ============================================================================
`default_nettype none

module pwm_channel_shadow
    import wbs_pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             duty_we,
    input  logic [CNT_W-1:0] duty_wdata,
    input  logic             load,
    input  logic             enable,
    input  logic             run,
    input  logic [CNT_W-1:0] counter,
    output logic [CNT_W-1:0] shadow,
    output logic             pwm
);

    logic [CNT_W-1:0] active;

    // load samples the pre-write shadow, so a write coinciding with a wrap
    // only becomes active at the following wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (duty_we) shadow <= duty_wdata;
            if (load)    active <= shadow;
            pwm <= enable & run & (active > counter);
        end
    end

endmodule

`default_nettype wire

// File: rtl/wbs_pwm_ctrl.sv
// ============================================================================
// wbs_pwm_ctrl : Wishbone-slave PWM controller with prescaler and shadow duty
// Revision     : 1.0
// ============================================================================
`default_nettype none

module wbs_pwm_ctrl
    import wbs_pwm_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [2:0]       wb_adr_i,
    input  logic [DAT_W-1:0] wb_dat_i,
    output logic [DAT_W-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_stall_o,
    output logic [NCH-1:0]   pwm_o,
    output logic             period_o
);

    logic             accept;
    logic             wr;
    logic             presc_wr;
    logic             tick;
    logic             wrap;
    logic             run;
    logic [NCH-1:0]   enable;
    logic [CNT_W-1:0] prescale;
    logic [CNT_W-1:0] presc_cnt;
    logic [CNT_W-1:0] counter;
    logic [DAT_W-1:0] rd_mux;
    logic [DAT_W-1:0] rd_data;
    logic [CNT_W-1:0] shadow [NCH];

    assign accept     = wb_cyc_i & wb_stb_i;
    assign wr         = accept & wb_we_i;
    assign presc_wr   = wr && (wb_adr_i == ADR_PRESCALE);
    assign tick       = run && (presc_cnt == prescale);
    assign wrap       = tick && (counter == {CNT_W{1'b1}});
    assign wb_stall_o = 1'b0;
    assign wb_dat_o   = rd_data;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            prescale <= '0;
            enable   <= '0;
            run      <= 1'b0;
        end else if (wr) begin
            if (wb_adr_i == ADR_PRESCALE) prescale <= wb_dat_i;
            if (wb_adr_i == ADR_CONTROL) begin
                enable <= wb_dat_i[NCH-1:0];
                run    <= wb_dat_i[CTRL_RUN];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || !run) begin
            counter   <= '0;
            presc_cnt <= '0;
        end else begin
            if (tick) counter <= counter + 1'b1;
            if (tick || presc_wr) presc_cnt <= '0;
            else                  presc_cnt <= presc_cnt + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            period_o <= 1'b0;
            wb_ack_o <= 1'b0;
            rd_data  <= '0;
        end else begin
            period_o <= wrap;
            wb_ack_o <= accept;
            rd_data  <= (accept && !wb_we_i) ? rd_mux : '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int n = 0; n < NCH; n++) begin
            if (wb_adr_i == 3'(n)) rd_mux = shadow[n];
        end
        case (wb_adr_i)
            ADR_PRESCALE: rd_mux = prescale;
            ADR_CONTROL: begin
                rd_mux[NCH-1:0] = enable;
                rd_mux[CTRL_RUN] = run;
            end
            ADR_COUNTER:  rd_mux = counter;
            default: ;
        endcase
    end

    // while stopped the active duty follows shadow every cycle
    for (genvar n = 0; n < NCH; n++) begin : g_ch
        pwm_channel_shadow u_ch (
            .clk        (wb_clk_i),
            .rst_n      (wb_rst_ni),
            .duty_we    (wr && (wb_adr_i == 3'(n))),
            .duty_wdata (wb_dat_i),
            .load       (wrap | ~run),
            .enable     (enable[n]),
            .run        (run),
            .counter    (counter),
            .shadow     (shadow[n]),
            .pwm        (pwm_o[n])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_wbs_pwm_ctrl.sv
// ============================================================================
// tb_wbs_pwm_ctrl : scoreboard bench for wbs_pwm_ctrl against a reference model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_wbs_pwm_ctrl;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [2:0]     adr = '0;
    logic [7:0]     dat = '0;
    logic [7:0]     dat_o;
    logic           ack, stall, period;
    logic [NCH-1:0] pwm;

    wbs_pwm_ctrl #(.NCH(NCH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rstn),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat),
        .wb_dat_o   (dat_o),
        .wb_ack_o   (ack),
        .wb_stall_o (stall),
        .pwm_o      (pwm),
        .period_o   (period)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state, plain integers
    int m_shadow [NCH];
    int m_active [NCH];
    int m_pre, m_en, m_run, m_cnt, m_pc;
    bit m_ack, m_period;
    int m_pwm;
    int exp_q [$];
    int last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_read(input int a);
        if (a < NCH) return m_shadow[a];
        case (a)
            4: return m_pre;
            5: return (m_run << 7) | m_en;
            6: return m_cnt;
            default: return 0;
        endcase
    endfunction

    // advance the model by one clock edge using the inputs present at that edge
    function automatic void model_step();
        bit acc, tk, wr_end;
        int nxt_pwm;
        if (!rstn) begin
            foreach (m_shadow[n]) begin m_shadow[n] = 0; m_active[n] = 0; end
            m_pre = 0; m_en = 0; m_run = 0; m_cnt = 0; m_pc = 0;
            m_ack = 0; m_period = 0; m_pwm = 0;
            return;
        end
        acc = cyc && stb;
        m_ack = acc;
        if (acc) exp_q.push_back(we ? -1 : m_read(int'(adr)));
        nxt_pwm = 0;
        for (int n = 0; n < NCH; n++)
            if (m_run != 0 && ((m_en >> n) & 1) != 0 && m_active[n] > m_cnt)
                nxt_pwm |= (1 << n);
        m_pwm = nxt_pwm;
        // a tick happens once every prescale+1 running cycles
        tk = (m_run != 0) && (m_pc == m_pre);
        wr_end = tk && (m_cnt == 255);
        m_period = wr_end;
        for (int n = 0; n < NCH; n++)
            if (m_run == 0 || wr_end) m_active[n] = m_shadow[n];
        if (m_run == 0) begin
            m_cnt = 0; m_pc = 0;
        end else begin
            if (tk) m_cnt = (m_cnt + 1) % 256;
            m_pc = (tk || (acc && we && adr == 3'd4)) ? 0 : m_pc + 1;
        end
        if (acc && we) begin
            if (int'(adr) < NCH) m_shadow[adr] = int'(dat);
            else if (adr == 3'd4) m_pre = int'(dat);
            else if (adr == 3'd5) begin
                m_en  = int'(dat) & ((1 << NCH) - 1);
                m_run = int'(dat[7]);
            end
        end
    endfunction

    task automatic tick_clk();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic xfer(input bit w, input int a, input int d);
        cyc = 1'b1; stb = 1'b1; we = w; adr = 3'(a); dat = 8'(d);
        tick_clk();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            tick_clk();
            n++;
        end while (!period && n < limit);
        if (!period) begin
            checks++; errors++;
            $display("FAIL period_timeout: no period_o within %0d cycles", limit);
        end
    endtask

    // monitor: pops expected read data on every ack, checks outputs each cycle
    always @(posedge clk) begin
        int e;
        #2;
        chk("ack", ack, m_ack);
        chk("stall", stall, 0);
        if (ack) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ack_unexpected: ack with no pending transfer at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (e >= 0) chk("rdata", dat_o, e);
                last_rd = int'(dat_o);
            end
        end else begin
            chk("dat_idle", dat_o, 0);
        end
        chk("pwm", pwm, m_pwm);
        chk("period", period, m_period);
    end

    initial begin
        int n, hi, hi2, pulses, r1, r2, guard;
        repeat (3) tick_clk();
        rstn = 1'b1;
        tick_clk();

        // duty0=64, prescale 0, run with ch0 enabled
        xfer(1, 0, 64);
        xfer(1, 4, 0);
        xfer(1, 5, 8'h81);
        wait_pulse(2000, n);
        hi = 0; pulses = 0;
        for (int i = 1; i <= 256; i++) begin
            tick_clk();
            hi += int'(pwm[0]);
            pulses += int'(period);
        end
        chk("pwm0_high_64", hi, 64);
        chk("period_at_256", period, 1);
        chk("one_pulse_per_256", pulses, 1);

        // prescale 3: wraps every 1024 cycles, counter steps once per 4 cycles
        xfer(1, 4, 3);
        tick_clk();
        xfer(0, 6, 0);
        #2 r1 = last_rd;
        repeat (3) tick_clk();
        xfer(0, 6, 0);
        #2 r2 = last_rd;
        chk("cnt_diff_4cyc", (r2 - r1) & 255, 1);
        wait_pulse(2000, n);
        wait_pulse(2000, n);
        chk("period_1024", n, 1024);

        // duty change mid-period takes effect only after the next wrap
        guard = 0;
        while (m_cnt != 100 && guard < 3000) begin tick_clk(); guard++; end
        chk("reach_cnt_100", m_cnt, 100);
        xfer(1, 0, 200);
        wait_pulse(2000, n);
        hi = 0;
        for (int i = 0; i < 1024; i++) begin
            tick_clk();
            hi += int'(pwm[0]);
        end
        chk("pwm0_high_800", hi, 800);

        // duty write on the very edge of a wrap
        guard = 0;
        while (!(m_run != 0 && m_pc == m_pre && m_cnt == 255) && guard < 3000) begin
            tick_clk(); guard++;
        end
        chk("reach_wrap_edge", m_cnt, 255);
        xfer(1, 0, 50);
        chk("wrap_with_write", period, 1);
        repeat (40) tick_clk();

        // duty extremes on channels 1 and 2
        xfer(1, 4, 0);
        xfer(1, 1, 255);
        xfer(1, 2, 0);
        xfer(1, 5, 8'h8F);
        wait_pulse(2000, n);
        wait_pulse(2000, n);
        hi = 0; hi2 = 0;
        for (int i = 0; i < 256; i++) begin
            tick_clk();
            hi  += int'(pwm[1]);
            hi2 += int'(pwm[2]);
        end
        chk("duty255_high", hi, 255);
        chk("duty0_high", hi2, 0);

        // back-to-back reads with strobe held, then an unmapped address
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        for (int a = 0; a < 4; a++) begin adr = 3'(a); tick_clk(); end
        adr = 3'd7; tick_clk();
        cyc = 1'b0; stb = 1'b0;
        xfer(1, 6, 8'hAA);
        xfer(1, 7, 8'h55);
        repeat (2) tick_clk();

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                cyc = 1'b1; stb = 1'b1;
                we  = 1'($urandom_range(0, 1));
                adr = 3'($urandom_range(0, 7));
                dat = 8'($urandom);
                if (adr == 3'd4) dat = 8'($urandom_range(0, 3));
                if (adr == 3'd5) dat[7] = ($urandom_range(0, 9) < 8);
            end else begin
                cyc = 1'($urandom_range(0, 1)); stb = 1'b0;
            end
            tick_clk();
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        xfer(1, 5, 8'h8F);
        repeat (300) tick_clk();

        // one-cycle reset with a transfer presented in the same cycle
        rstn = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd0; dat = 8'h77;
        tick_clk();
        rstn = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("rst_no_ack", ack, 0);
        chk("rst_pwm", pwm, 0);
        for (int a = 0; a < 8; a++) xfer(0, a, 0);
        repeat (3) tick_clk();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wbs_pwm_ctrl.md
WBS_PWM_CTRL -- requirements
Module: wbs_pwm_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of PWM channels, legal range 1..4.
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port wb_cyc_i, input, 1 bit: Wishbone cycle.
REQ-005 SHALL have port wb_stb_i, input, 1 bit: Wishbone strobe.
REQ-006 SHALL have port wb_we_i, input, 1 bit: write enable.
REQ-007 SHALL have port wb_adr_i, input, 3 bits: register address.
REQ-008 SHALL have port wb_dat_i, input, 8 bits: write data.
REQ-009 SHALL have port wb_dat_o, output, 8 bits: read data.
REQ-010 SHALL have port wb_ack_o, output, 1 bit: transfer acknowledge.
REQ-011 SHALL have port wb_stall_o, output, 1 bit: pipeline stall, tied to 0.
REQ-012 SHALL have port pwm_o, output, NCH bits: registered PWM outputs.
REQ-013 SHALL have port period_o, output, 1 bit: one-cycle pulse at each counter wrap.

Function
REQ-014 SHALL accept a transfer in every cycle where wb_cyc_i and wb_stb_i are both 1, with no stalls, including back-to-back transfers.
REQ-015 SHALL assert wb_ack_o exactly one cycle after each accepted transfer; read data SHALL be valid on wb_dat_o in that same cycle, and wb_dat_o SHALL be 0 when ack is 0.
REQ-016 SHALL implement this register map:
- addresses 0..NCH-1: shadow duty of channel n (RW);
- address 4: prescale (RW);
- address 5: control (RW; bits[NCH-1:0] per-channel enable, bit7 run);
- address 6: counter (RO; value at accept time);
- all other addresses: writes ignored, reads return 0.
REQ-017 Writes to a RO or unmapped address SHALL still be acknowledged.
REQ-018 SHALL keep an 8-bit prescaler count; when run=1 it SHALL increment each cycle, and when it equals prescale it SHALL produce a tick and return to 0 on the next cycle (tick period = prescale+1 cycles).
REQ-019 A write to prescale SHALL clear the prescaler count in the same edge.
REQ-020 On each tick the 8-bit PWM counter SHALL increment modulo 256; a tick while the counter is 255 is a wrap.
REQ-021 On a wrap, every active duty register SHALL load its shadow duty, and period_o SHALL pulse for 1 cycle.
REQ-022 If a duty write and a wrap occur in the same cycle, active duty SHALL load the pre-write shadow value; the new value takes effect at the next wrap.
REQ-023 When run=0, the counter and prescaler count SHALL be held at 0, active duty SHALL track shadow duty every cycle, and pwm_o SHALL be 0.
REQ-024 pwm_o[n] SHALL be registered as enable[n] & run & (active_duty[n] > counter), giving one cycle of latency after the counter value.
REQ-025 Duty 0 SHALL give a constant 0 output; duty 255 SHALL give output high for 255 of 256 counter values.
REQ-026 Disabling a channel SHALL force its output to 0 on the next cycle, without affecting the counter.

Reset
REQ-027 When wb_rst_ni=0 at a clock edge, all registers SHALL be cleared: shadow duty, active duty, prescale, control, counter and prescaler count = 0; wb_ack_o=0, pwm_o=0, period_o=0.
REQ-028 A transfer accepted in a reset cycle SHALL NOT be acknowledged, and reset SHALL override a simultaneous write.

Structure
REQ-029 Register address constants, the control bit positions (RUN=7) and the counter width SHALL live in a shared package, wbs_pwm_pkg.
REQ-030 Per-channel shadow/active duty, the compare and the output flop SHALL be one sub-module, pwm_channel_shadow, instantiated NCH times.

Verification
REQ-031 Write duty0=64, prescale=0, control=0x81: pwm_o[0] is high for 64 of every 256 cycles and period_o pulses every 256 cycles.
REQ-032 Write prescale=3: period_o spacing becomes 1024 cycles; reading address 6 twice, 4 cycles apart, differs by 1.
REQ-033 Write duty0=200 mid-period, at counter=100: the duty stays 64 until the next period_o, then the output is high for 200 counts; the same-cycle write/wrap case follows REQ-022.
REQ-034 Four back-to-back reads of addresses 0..3, stb held for 4 cycles: four consecutive acks returning the written duties in order; a read of address 7 returns 0 and is acked.
REQ-035 Pull wb_rst_ni low for 1 cycle mid-period with an outstanding transfer: no ack, pwm_o=0, all readback values 0.
REQ-036 Duty=255 with the channel enabled: the output is low only when counter=255; duty=0: the output is never high.
